// File: rtl/cu_sequencer_if.sv
// Bundle between the sequencer and its environment: instruction, sub-CU proposals,
// memory/ALU status in; state, flags and the datapath control word out.
interface cu_sequencer_if #(
    parameter int CUL = 35
);
    logic [31:0]  IR;
    logic [CUL:0] imm_cw;
    logic [CUL:0] reg_cw;
    logic [CUL:0] mem_cw;
    logic [CUL:0] br_cw;
    logic [3:0]   imm_ns;
    logic [3:0]   reg_ns;
    logic [3:0]   mem_ns;
    logic [3:0]   br_ns;
    logic         mem_ready;
    logic [3:0]   alu_flags;
    logic [3:0]   state;
    logic [3:0]   status;
    logic [CUL:0] controlWord;
    logic         halted;

    modport slave (
        input  IR, imm_cw, reg_cw, mem_cw, br_cw,
        input  imm_ns, reg_ns, mem_ns, br_ns, mem_ready, alu_flags,
        output state, status, controlWord, halted
    );

    modport master (
        output IR, imm_cw, reg_cw, mem_cw, br_cw,
        output imm_ns, reg_ns, mem_ns, br_ns, mem_ready, alu_flags,
        input  state, status, controlWord, halted
    );
endinterface

// File: rtl/cu_sequencer.sv
// Multi-cycle CPU top sequencer: runs FETCH, muxes per-class sub-CU control words,
// stalls on memory, keeps NZCV flags, and traps undefined opcodes / runaway EX to HALT.
module cu_sequencer #(
    parameter int CUL           = 35,
    parameter int MAX_EX_CYCLES = 8
) (
    input  logic           clock,
    input  logic           reset_n,
    cu_sequencer_if.slave  bus
);
    localparam int W_REG       = 15;
    localparam int MEM_CS_LO   = 12;
    localparam int MEM_WR      = 10;
    localparam int IR_LOAD     = 9;
    localparam int STATUS_LOAD = 8;
    localparam int PC_FS_LO    = 0;
    localparam int CNT_W       = $clog2(MAX_EX_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_EX_CYCLES - 1);

    typedef enum logic [3:0] {
        ST_FETCH = 4'd0,
        ST_EX0, ST_EX1, ST_EX2, ST_EX3, ST_EX4, ST_EX5, ST_EX6,
        ST_EX7, ST_EX8, ST_EX9, ST_EX10, ST_EX11, ST_EX12, ST_EX13,
        ST_HALT
    } state_e;

    typedef enum logic [2:0] {CLS_IMM, CLS_BR, CLS_REG, CLS_MEM, CLS_UNDEF} cls_e;

    state_e           state_reg, state_next;
    logic [3:0]       status_reg;
    logic [CNT_W-1:0] ex_cnt_reg, ex_cnt_next;
    logic             halted_reg;
    logic [CUL:0]     ctrl_word;
    logic [CUL:0]     sel_cw;
    logic [3:0]       sel_ns;
    logic [3:0]       opc;
    cls_e             cls;
    logic             stall;
    logic             unused_ir;

    assign opc       = bus.IR[28:25];
    assign unused_ir = ^{bus.IR[31:29], bus.IR[24:0]};

    // Overlapping patterns resolve IMM > BR > REG > MEM.
    always_comb begin
        cls = CLS_UNDEF;
        if (opc[3:1] == 3'b100)
            cls = CLS_IMM;
        else if (opc[3:1] == 3'b101)
            cls = CLS_BR;
        else if (opc[2:0] == 3'b101)
            cls = CLS_REG;
        else if (opc[2] && !opc[0])
            cls = CLS_MEM;
    end

    always_comb begin
        sel_cw = '0;
        sel_ns = 4'b0000;
        case (cls)
            CLS_IMM: begin sel_cw = bus.imm_cw; sel_ns = bus.imm_ns; end
            CLS_BR:  begin sel_cw = bus.br_cw;  sel_ns = bus.br_ns;  end
            CLS_REG: begin sel_cw = bus.reg_cw; sel_ns = bus.reg_ns; end
            CLS_MEM: begin sel_cw = bus.mem_cw; sel_ns = bus.mem_ns; end
            default: begin sel_cw = '0;         sel_ns = 4'b0000;    end
        endcase
    end

    assign stall = (sel_cw[MEM_CS_LO +: 2] != 2'b00) && !bus.mem_ready;

    always_comb begin
        ctrl_word   = '0;
        state_next  = state_reg;
        ex_cnt_next = ex_cnt_reg;
        case (state_reg)
            ST_FETCH: begin
                ctrl_word[IR_LOAD]          = 1'b1;
                ctrl_word[MEM_CS_LO +: 2]   = 2'b01;
                ex_cnt_next                 = '0;
                if (bus.mem_ready) begin
                    ctrl_word[PC_FS_LO +: 2] = 2'b01;
                    state_next               = ST_EX0;
                end
            end
            ST_HALT: begin
                state_next  = ST_HALT;
                ex_cnt_next = '0;
            end
            default: begin
                if (cls == CLS_UNDEF) begin
                    state_next = ST_HALT;
                end else if (stall) begin
                    // Hold state and suppress every architectural write until memory answers.
                    ctrl_word                = sel_cw;
                    ctrl_word[W_REG]         = 1'b0;
                    ctrl_word[STATUS_LOAD]   = 1'b0;
                    ctrl_word[MEM_WR]        = 1'b0;
                    ctrl_word[IR_LOAD]       = 1'b0;
                    ctrl_word[PC_FS_LO +: 2] = 2'b00;
                end else begin
                    ctrl_word   = sel_cw;
                    ex_cnt_next = ex_cnt_reg + 1'b1;
                    if (sel_ns == 4'b0000)
                        state_next = ST_FETCH;
                    else if (sel_ns == 4'b1111 || ex_cnt_reg >= CNT_LAST)
                        state_next = ST_HALT;
                    else
                        state_next = state_e'(sel_ns);
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= ST_FETCH;
            status_reg <= 4'b0000;
            ex_cnt_reg <= '0;
            halted_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            ex_cnt_reg <= ex_cnt_next;
            halted_reg <= (state_next == ST_HALT);
            if (ctrl_word[STATUS_LOAD])
                status_reg <= bus.alu_flags;
        end
    end

    assign bus.state       = state_reg;
    assign bus.status      = status_reg;
    assign bus.controlWord = ctrl_word;
    assign bus.halted      = halted_reg;
endmodule
